// File: rtl/aes_key_schedule.sv
// AES key expansion for 128/192/256-bit keys. After a start request it writes
// one schedule word per cycle into a register array. Round keys can be read
// while expansion is still running; rounds_ready says how many are complete.

// Combinational AES S-box. The table is packed row-major with entry 0 in the
// most significant byte.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  // Entry a sits at byte position 255-a, i.e. bit offset (~a)*8.
  assign out_o = SBOX_TABLE[{~in_i, 3'b000} +: 8];
endmodule

module aes_key_schedule #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                done,
  output logic                key_valid,
  output logic [3:0]          rounds_ready,
  input  logic [3:0]          rd_round,
  output logic [127:0]        rd_key,
  output logic [1:0]          dbg_state_o
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key_bits
    $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
  end

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [5:0]  i_q, i_d;        // index of the next word to write
  logic [2:0]  wrap_q, wrap_d;  // i mod NK, kept as a wrapping counter
  logic [7:0]  rcon_q, rcon_d;
  logic [3:0]  rr_q, rr_d;      // completed round keys
  logic        kv_q, kv_d;
  logic [31:0] w_q [NW];

  logic [31:0] prev_w, old_w, rot_w, sub_in, sub_out, t_w, new_w;
  logic [7:0]  rcon_nx;
  logic [5:0]  rd_base;

  assign prev_w  = w_q[i_q - 6'd1];
  assign old_w   = w_q[i_q - 6'(NK)];
  assign rot_w   = {prev_w[23:0], prev_w[31:24]};
  assign sub_in  = (wrap_q == 3'd0) ? rot_w : prev_w;
  assign rcon_nx = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.in_i(sub_in[8*b +: 8]), .out_o(sub_out[8*b +: 8]));
  end

  // Temp-word transform and the new schedule word.
  always_comb begin
    t_w = prev_w;
    if (wrap_q == 3'd0) begin
      t_w = sub_out ^ {rcon_q, 24'h0};
    end else if (NK == 8 && wrap_q == 3'd4) begin
      t_w = sub_out;
    end
    new_w = old_w ^ t_w;
  end

  // FSM and counter next-state logic.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    wrap_d  = wrap_q;
    rcon_d  = rcon_q;
    rr_d    = rr_q;
    kv_d    = kv_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_EXPAND;
          i_d     = 6'(NK);
          wrap_d  = 3'd0;
          rcon_d  = 8'h01;
          rr_d    = 4'(NK / 4);
          kv_d    = 1'b0;
        end
      end
      S_EXPAND: begin
        i_d    = i_q + 6'd1;
        wrap_d = (wrap_q == 3'(NK - 1)) ? 3'd0 : wrap_q + 3'd1;
        if (wrap_q == 3'd0) rcon_d = rcon_nx;
        rr_d   = i_d[5:2];
        if (i_q == 6'(NW - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        kv_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= 6'd0;
      wrap_q  <= 3'd0;
      rcon_q  <= 8'h01;
      rr_q    <= 4'd0;
      kv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      wrap_q  <= wrap_d;
      rcon_q  <= rcon_d;
      rr_q    <= rr_d;
      kv_q    <= kv_d;
    end
  end

  // Schedule storage: key words on accept, one generated word per EXPAND cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_IDLE && start) begin
        for (int k = 0; k < NK; k++) begin
          w_q[k] <= key_in[KEY_BITS - 1 - 32*k -: 32];
        end
      end else if (state_q == S_EXPAND) begin
        w_q[i_q] <= new_w;
      end
    end
  end

  assign rd_base      = {rd_round, 2'b00};
  assign rd_key       = (rd_round < rr_q) ?
                        {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]} :
                        128'h0;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign key_valid    = kv_q;
  assign rounds_ready = rr_q;
  assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule using the FIPS-197 expansion vectors
// for all three key sizes.
module tb_aes_key_schedule;
  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R1_128  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R2_128  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] R10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R12_192 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start_128 = 0, start_192 = 0, start_256 = 0;
  logic [3:0]   rd_128 = 0, rd_192 = 0, rd_256 = 0;
  logic         busy_128, done_128, kv_128, busy_192, done_192, kv_192, busy_256, done_256, kv_256;
  logic [3:0]   rr_128, rr_192, rr_256;
  logic [127:0] key_128, key_192, key_256;
  logic [1:0]   st_128, st_192, st_256;

  aes_key_schedule #(.KEY_BITS(128)) u128 (
    .clk(clk), .rst(rst), .start(start_128), .key_in(K128), .busy(busy_128), .done(done_128),
    .key_valid(kv_128), .rounds_ready(rr_128), .rd_round(rd_128), .rd_key(key_128), .dbg_state_o(st_128));
  aes_key_schedule #(.KEY_BITS(192)) u192 (
    .clk(clk), .rst(rst), .start(start_192), .key_in(K192), .busy(busy_192), .done(done_192),
    .key_valid(kv_192), .rounds_ready(rr_192), .rd_round(rd_192), .rd_key(key_192), .dbg_state_o(st_192));
  aes_key_schedule #(.KEY_BITS(256)) u256 (
    .clk(clk), .rst(rst), .start(start_256), .key_in(K256), .busy(busy_256), .done(done_256),
    .key_valid(kv_256), .rounds_ready(rr_256), .rd_round(rd_256), .rd_key(key_256), .dbg_state_o(st_256));

  // Scoreboard counters and the single checker
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one cycle; sample and drive 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // After the accept edge, wait for done on the 128-bit instance; lat counts
  // edges from the accept edge inclusive, 0 if done never appears.
  task automatic wait_done_128(output int lat);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (done_128) begin
        lat = k + 1;
        break;
      end
    end
  endtask

  int lat, lat192, lat256;

  initial begin
    // Reset state
    tick(); tick();
    check("rst_busy", 128'(busy_128), 128'd0);
    check("rst_done", 128'(done_128), 128'd0);
    check("rst_kv", 128'(kv_128), 128'd0);
    check("rst_rr", 128'(rr_128), 128'd0);
    check("rst_rdkey", key_128, 128'h0);
    check("rst_rr256", 128'(rr_256), 128'd0);
    rst = 1'b0;

    // 128-bit expansion, polling round 2 while it runs
    rd_128 = 4'd2;
    start_128 = 1'b1;
    tick();
    start_128 = 1'b0;
    check("poll_rr_e0", 128'(rr_128), 128'd1);
    check("poll_key_e0", key_128, 128'h0);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      check($sformatf("poll_rr_e%0d", k), 128'(rr_128), 128'((4 + (k > 40 ? 40 : k)) / 4));
      check($sformatf("poll_key_e%0d", k), key_128, ((4 + k) / 4 >= 3) ? R2_128 : 128'h0);
      if (done_128) begin
        lat = k + 1;
        break;
      end
    end
    check("lat_128", 128'(lat), 128'd41);
    check("busy_at_done", 128'(busy_128), 128'd1);
    check("kv_at_done", 128'(kv_128), 128'd0);
    rd_128 = 4'd0;  #1 check("r0_128", key_128, K128);
    rd_128 = 4'd1;  #1 check("r1_128", key_128, R1_128);
    rd_128 = 4'd10; #1 check("r10_128", key_128, R10_128);
    rd_128 = 4'd11; #1 check("r11_128_zero", key_128, 128'h0);
    rd_128 = 4'd15; #1 check("r15_128_zero", key_128, 128'h0);
    tick();
    check("kv_after", 128'(kv_128), 128'd1);
    check("busy_after", 128'(busy_128), 128'd0);
    check("done_pulse", 128'(done_128), 128'd0);

    // 192- and 256-bit expansions side by side
    start_192 = 1'b1; start_256 = 1'b1;
    tick();
    start_192 = 1'b0; start_256 = 1'b0;
    lat192 = 0; lat256 = 0;
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (done_192 && lat192 == 0) lat192 = k + 1;
      if (done_256 && lat256 == 0) lat256 = k + 1;
      if (lat192 != 0 && lat256 != 0) break;
    end
    check("lat_192", 128'(lat192), 128'd47);
    check("lat_256", 128'(lat256), 128'd53);
    check("rr_192", 128'(rr_192), 128'd13);
    check("rr_256", 128'(rr_256), 128'd15);
    rd_192 = 4'd12; rd_256 = 4'd14;
    #1;
    check("r12_192", key_192, R12_192);
    check("r14_256", key_256, R14_256);
    rd_192 = 4'd0; rd_256 = 4'd0;
    #1;
    check("r0_192", key_192, K192[191:64]);
    check("r0_256", key_256, K256[255:128]);
    rd_192 = 4'd13;
    #1 check("r13_192_zero", key_192, 128'h0);
    tick();
    check("kv_192", 128'(kv_192), 128'd1);
    check("kv_256", 128'(kv_256), 128'd1);

    // start held high throughout: one expansion, re-accepted after DONE
    rd_128 = 4'd10;
    start_128 = 1'b1;
    tick();
    check("spam_kv_clr", 128'(kv_128), 128'd0);
    wait_done_128(lat);
    check("spam_lat", 128'(lat), 128'd41);
    tick();
    check("spam_idle_busy", 128'(busy_128), 128'd0);
    check("spam_idle_done", 128'(done_128), 128'd0);
    check("spam_idle_kv", 128'(kv_128), 128'd1);
    tick();
    start_128 = 1'b0;
    check("spam_reaccept_busy", 128'(busy_128), 128'd1);
    check("spam_reaccept_kv", 128'(kv_128), 128'd0);
    check("spam_reaccept_rr", 128'(rr_128), 128'd1);
    wait_done_128(lat);
    check("spam2_lat", 128'(lat), 128'd41);
    check("spam2_r10", key_128, R10_128);
    tick();

    // Reset in the middle of an expansion
    start_128 = 1'b1;
    tick();
    start_128 = 1'b0;
    repeat (19) tick();
    check("mid_busy_pre", 128'(busy_128), 128'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_busy", 128'(busy_128), 128'd0);
    check("mid_rst_done", 128'(done_128), 128'd0);
    check("mid_rst_kv", 128'(kv_128), 128'd0);
    check("mid_rst_rr", 128'(rr_128), 128'd0);
    check("mid_rst_rdkey", key_128, 128'h0);
    rst = 1'b0;
    start_128 = 1'b1;
    tick();
    start_128 = 1'b0;
    wait_done_128(lat);
    check("post_rst_lat", 128'(lat), 128'd41);
    check("post_rst_r10", key_128, R10_128);
    tick();

    // rst and start together: reset wins
    rst = 1'b1; start_128 = 1'b1;
    tick();
    check("rst_wins_busy", 128'(busy_128), 128'd0);
    check("rst_wins_rr", 128'(rr_128), 128'd0);
    rst = 1'b0; start_128 = 1'b0;
    tick();
    check("rst_wins_idle", 128'(busy_128), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
